lna_spi_cfg_slave: RTL

- Serial configuration responder at the analog front-end end of the LNA control path.
- Receives 3-wire SPI-style frames (sen, sclk, sdi) from the off-block serial master and drives the LNA static controls pd, mode and gain.
- Supports register readback on sdo.
- Oversamples all serial inputs in the clk domain; no logic is clocked by sclk.

---
 rtl/lna_spi_pkg.sv | 22 ++
 rtl/lna_spi_sync_edge.sv | 32 +++
 rtl/lna_spi_cfg_slave.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/lna_spi_pkg.sv
// Shared types and constants for the LNA serial configuration slave.
// State encoding, register map addresses and frame length helper.
package lna_spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CMD,
        ST_DATA,
        ST_END
    } state_e;

    localparam int unsigned LNA_PD   = 0;
    localparam int unsigned LNA_MODE = 1;
    localparam int unsigned LNA_GAIN = 2;
    localparam int unsigned LNA_ID   = 3;

    function automatic int unsigned frame_w(input int unsigned aw,
                                            input int unsigned dw);
        return 1 + aw + dw;
    endfunction

endpackage

// File: rtl/lna_spi_sync_edge.sv
// Multi-flop synchronizer with rise/fall pulse detection on the
// synchronized level; pulses are combinational and last one clk.
module lna_spi_sync_edge #(
    parameter int unsigned STAGES  = 2,
    parameter logic        RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign q_o    = sync_q[STAGES-1];
    assign rise_o = sync_q[STAGES-1] & ~prev_q;
    assign fall_o = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/lna_spi_cfg_slave.sv
// 3-wire serial config slave driving LNA pd/mode/gain with readback.
// All serial pins are oversampled in clk; sclk is never used as a clock.
module lna_spi_cfg_slave
    import lna_spi_pkg::*;
#(
    parameter int unsigned ADDR_W      = 3,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] ID_VAL = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sen,
    input  logic       sclk,
    input  logic       sdi,
    output logic       sdo,
    output logic       sdo_oe,
    output logic       pd,
    output logic [1:0] mode,
    output logic [3:0] gain,
    output logic       cfg_upd,
    output logic       frame_err
);

    localparam int unsigned FRAME_W = frame_w(ADDR_W, DATA_W);
    localparam int unsigned CNT_W   = $clog2(FRAME_W + 2);
    localparam logic [CNT_W-1:0] CNT_CMD  = CNT_W'(ADDR_W);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(FRAME_W + 1);

    logic sen_s, sen_rise, sen_fall;
    logic sclk_s, sclk_rise, sclk_fall;
    logic [SYNC_STAGES-1:0] sdi_sync_q;
    logic sdi_s;

    lna_spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sen (
        .clk(clk), .rst(rst), .d_i(sen),
        .q_o(sen_s), .rise_o(sen_rise), .fall_o(sen_fall)
    );

    lna_spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
        .clk(clk), .rst(rst), .d_i(sclk),
        .q_o(sclk_s), .rise_o(sclk_rise), .fall_o(sclk_fall)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sdi_sync_q <= '0;
        else     sdi_sync_q <= {sdi_sync_q[SYNC_STAGES-2:0], sdi};
    end
    assign sdi_s = sdi_sync_q[SYNC_STAGES-1];

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   shift_q, shift_d, shift_in;
    logic [DATA_W-1:0]   rd_sr_q, rd_sr_d, rd_val;
    logic [ADDR_W-1:0]   addr_q, addr_d, cmd_addr;
    logic                rw_q, rw_d, cmd_rw;
    logic                pd_q, pd_d;
    logic [1:0]          mode_q, mode_d;
    logic [3:0]          gain_q, gain_d;
    logic                sdo_q, sdo_d, sdo_oe_q, sdo_oe_d;
    logic                upd_q, upd_d, err_q, err_d;

    assign shift_in = {shift_q[DATA_W-2:0], sdi_s};
    assign cmd_rw   = shift_in[ADDR_W];
    assign cmd_addr = shift_in[ADDR_W-1:0];

    // Snapshot source for readback, sampled as the address completes
    always_comb begin
        rd_val = '0;
        case (cmd_addr)
            ADDR_W'(LNA_PD):   rd_val = DATA_W'(pd_q);
            ADDR_W'(LNA_MODE): rd_val = DATA_W'(mode_q);
            ADDR_W'(LNA_GAIN): rd_val = DATA_W'(gain_q);
            ADDR_W'(LNA_ID):   rd_val = ID_VAL;
            default:           rd_val = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            shift_q  <= '0;
            rd_sr_q  <= '0;
            addr_q   <= '0;
            rw_q     <= 1'b0;
            pd_q     <= 1'b0;
            mode_q   <= '0;
            gain_q   <= '0;
            sdo_q    <= 1'b0;
            sdo_oe_q <= 1'b0;
            upd_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shift_q  <= shift_d;
            rd_sr_q  <= rd_sr_d;
            addr_q   <= addr_d;
            rw_q     <= rw_d;
            pd_q     <= pd_d;
            mode_q   <= mode_d;
            gain_q   <= gain_d;
            sdo_q    <= sdo_d;
            sdo_oe_q <= sdo_oe_d;
            upd_q    <= upd_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        rd_sr_d  = rd_sr_q;
        addr_d   = addr_q;
        rw_d     = rw_q;
        pd_d     = pd_q;
        mode_d   = mode_q;
        gain_d   = gain_q;
        sdo_d    = sdo_q;
        sdo_oe_d = sdo_oe_q;
        upd_d    = 1'b0;
        err_d    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                sdo_d    = 1'b0;
                sdo_oe_d = 1'b0;
                if (sen_fall) begin
                    state_d = ST_CMD;
                    cnt_d   = '0;
                    shift_d = '0;
                    rw_d    = 1'b0;
                end
            end
            ST_CMD, ST_DATA: begin
                if (sen_fall) begin
                    err_d    = 1'b1;
                    state_d  = ST_CMD;
                    cnt_d    = '0;
                    shift_d  = '0;
                    rw_d     = 1'b0;
                    sdo_d    = 1'b0;
                    sdo_oe_d = 1'b0;
                end else if (sen_rise) begin
                    state_d  = ST_END;
                    sdo_d    = 1'b0;
                    sdo_oe_d = 1'b0;
                end else if (sclk_rise) begin
                    shift_d = shift_in;
                    if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
                    if (state_q == ST_CMD && cnt_q == CNT_CMD) begin
                        state_d = ST_DATA;
                        rw_d    = cmd_rw;
                        addr_d  = cmd_addr;
                        if (cmd_rw) begin
                            rd_sr_d  = rd_val;
                            sdo_oe_d = 1'b1;
                        end
                    end
                end else if (sclk_fall && state_q == ST_DATA && rw_q) begin
                    sdo_d   = rd_sr_q[DATA_W-1];
                    rd_sr_d = rd_sr_q << 1;
                end
            end
            ST_END: begin
                sdo_d    = 1'b0;
                sdo_oe_d = 1'b0;
                state_d  = ST_IDLE;
                if (sen_fall) begin
                    err_d   = 1'b1;
                    state_d = ST_CMD;
                    cnt_d   = '0;
                    shift_d = '0;
                    rw_d    = 1'b0;
                end else if (cnt_q != CNT_FULL) begin
                    err_d = 1'b1;
                end else if (!rw_q) begin
                    case (addr_q)
                        ADDR_W'(LNA_PD): begin
                            pd_d  = shift_q[0];
                            upd_d = 1'b1;
                        end
                        ADDR_W'(LNA_MODE): begin
                            mode_d = shift_q[1:0];
                            upd_d  = 1'b1;
                        end
                        ADDR_W'(LNA_GAIN): begin
                            gain_d = shift_q[3:0];
                            upd_d  = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign sdo       = sdo_q;
    assign sdo_oe    = sdo_oe_q;
    assign pd        = pd_q;
    assign mode      = mode_q;
    assign gain      = gain_q;
    assign cfg_upd   = upd_q;
    assign frame_err = err_q;

endmodule
